counter_control: RTL and testbench

Front-end control stage for the lab 4 up/down counter. It synchronizes and debounces two raw pushbuttons (run/pause, direction) and samples the max-count switches. It divides the board clock into a one-cycle `enable` tick and drives the counter's `enable`, `direction` and `max_count` inputs. All outputs are registered, and the counter runs on the same `clock`.

---
 rtl/counter_control.sv | 77 +++++++
 tb/tb_counter_control.sv | 133 +++++++++++++
 2 files changed

// File: rtl/counter_control.sv
// counter_control: syncs/debounces run and dir buttons, samples max switches, divides clock into enable ticks
module counter_control #(
  parameter int         CLOCK_HZ        = 50_000_000,
  parameter int         TICK_HZ         = 1,
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [2:0] MAX_DEFAULT     = 3'b101
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic [2:0] sw_max,
  output logic       enable,
  output logic       direction,
  output logic [2:0] max_count,
  output logic       running
);
  localparam int DIV = CLOCK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  // bit 0 run button, bit 1 dir button, bits 4:2 switches
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] stable_q, stable_d, prev_q, prev_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic enable_q, enable_d, direction_q, direction_d, running_q, running_d;
  logic [2:0] max_count_q, max_count_d;
  logic run_press, dir_press, tick;
  always_comb begin
    sync1_d = {sw_max, btn_dir, btn_run};
    sync2_d = sync1_q;
    prev_d = stable_q;
    stable_d = stable_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
      cnt_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + CW'(1) : '0;
    end
    run_press = stable_q[0] & ~prev_q[0];
    dir_press = stable_q[1] & ~prev_q[1];
    tick = running_q && div_q == DW'(DIV - 1);
    // a pause press overrides a coinciding tick
    enable_d = tick & ~run_press;
    running_d = running_q ^ run_press;
    direction_d = direction_q ^ dir_press;
    div_d = (!running_q || run_press || tick) ? '0 : div_q + DW'(1);
    max_count_d = running_q ? max_count_q : sync2_q[4:2];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
      div_q <= '0;
      enable_q <= 1'b0;
      direction_q <= 1'b0;
      running_q <= 1'b0;
      max_count_q <= MAX_DEFAULT;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      stable_q <= stable_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      enable_q <= enable_d;
      direction_q <= direction_d;
      running_q <= running_d;
      max_count_q <= max_count_d;
    end
  assign enable = enable_q;
  assign direction = direction_q;
  assign running = running_q;
  assign max_count = max_count_q;
endmodule

// File: tb/tb_counter_control.sv
// tb_counter_control: directed scenarios plus random button/switch activity against a behavioural model
module tb_counter_control;
  localparam int DIV = 10, DEB = 4;
  localparam logic [2:0] MAXD = 3'b101;
  logic clock = 1'b0, reset_n = 1'b1, btn_run = 1'b0, btn_dir = 1'b0;
  logic [2:0] sw_max = MAXD;
  logic enable, direction, running;
  logic [2:0] max_count;
  int total = 0, bad = 0;
  logic [4:0] m_s1, m_s2;
  logic [1:0] m_stable, m_prev;
  logic m_run, e_en, e_dir;
  logic [2:0] e_max;
  int m_age;
  logic [1:0] hist[$];

  counter_control #(.CLOCK_HZ(20), .TICK_HZ(2), .DEBOUNCE_CYCLES(DEB), .MAX_DEFAULT(MAXD)) dut (
    .clock(clock), .reset_n(reset_n), .btn_run(btn_run), .btn_dir(btn_dir), .sw_max(sw_max),
    .enable(enable), .direction(direction), .max_count(max_count), .running(running));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
    m_run = 1'b0; e_en = 1'b0; e_dir = 1'b0; e_max = MAXD; m_age = 0;
    hist.delete();
  endtask

  // m_age counts edges since running last rose; a tick is due every DIV edges
  task automatic model_edge();
    logic pr, pd, tk, all_diff;
    pr = m_stable[0] & ~m_prev[0];
    pd = m_stable[1] & ~m_prev[1];
    tk = m_run && (m_age % DIV == DIV - 1);
    e_en = tk && !pr;
    if (!m_run) e_max = m_s2[4:2];
    e_dir = e_dir ^ pd;
    m_age = (m_run && !pr) ? m_age + 1 : 0;
    m_run = m_run ^ pr;
    m_prev = m_stable;
    hist.push_back(m_s2[1:0]);
    if (hist.size() > DEB) void'(hist.pop_front());
    for (int b = 0; b < 2; b++) begin
      all_diff = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    m_s2 = m_s1;
    m_s1 = {sw_max, btn_dir, btn_run};
  endtask

  task automatic step(input logic r, input logic d, input logic [2:0] s);
    btn_run = r; btn_dir = d; sw_max = s;
    @(posedge clock);
    model_edge();
    #1;
    chk("enable", enable, e_en);
    chk("direction", direction, e_dir);
    chk("running", running, m_run);
    chk("max_count", max_count, e_max);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    btn_run = 1'b0; btn_dir = 1'b0;
    #1;
    chk("rst_enable", enable, 3'b000);
    chk("rst_direction", direction, 3'b000);
    chk("rst_running", running, 3'b000);
    chk("rst_max_count", max_count, MAXD);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
  endtask

  initial begin
    int hr, hd;
    logic rr, rd;
    logic [2:0] rs;
    hr = 0; hd = 0; rr = 1'b0; rd = 1'b0; rs = MAXD;
    do_reset();
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, MAXD);
    for (int j = 1; j <= 40; j++) begin
      step(j <= 10, 1'b0, MAXD);
      chk("s2_running", running, j >= 7);
      chk("s2_enable", enable, j >= 17 && (j - 17) % 10 == 0);
    end
    for (int j = 1; j <= 40; j++) begin
      step(1'b0, j <= 12 ? ((j - 1) / 2) % 2 == 0 : j <= 30, MAXD);
      chk("s3_direction", direction, j >= 19);
    end
    chk("s1_pre_running", running, 3'b001);
    do_reset();
    for (int j = 0; j < 10; j++) step(1'b0, 1'b0, MAXD);
    for (int j = 1; j <= 50; j++) begin
      step((j >= 5 && j <= 10) || (j >= 41 && j <= 46), 1'b0, j < 20 ? 3'b011 : 3'b110);
      if (j == 2) chk("s5_max_hold", max_count, MAXD);
      if (j >= 3 && j <= 47) chk("s5_max_frozen", max_count, 3'b011);
      if (j >= 48) chk("s5_max_reload", max_count, 3'b110);
      chk("s5_running", running, j >= 11 && j <= 46);
    end
    do_reset();
    for (int j = 1; j <= 70; j++) begin
      step(j <= 6 || (j >= 21 && j <= 26) || (j >= 41 && j <= 46), 1'b0, MAXD);
      chk("s4_running", running, (j >= 7 && j <= 26) || j >= 47);
      chk("s4_enable", enable, j == 17 || j == 57 || j == 67);
    end
    do_reset();
    for (int j = 1; j <= 40; j++) begin
      step(j <= 6, j >= 21 && j <= 26, MAXD);
      chk("s6_direction", direction, j >= 27);
      chk("s6_enable", enable, j == 17 || j == 27 || j == 37);
    end
    for (int k = 0; k < 800; k++) begin
      if (hr == 0) begin rr = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 8); end
      if (hd == 0) begin rd = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 8); end
      if ($urandom_range(0, 15) == 0) rs = 3'($urandom);
      hr--; hd--;
      if (k == 400) do_reset();
      step(rr, rd, rs);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
